// File: rtl/wb_pkg.sv
// Shared definitions for the writeback skid stage: widths, mux select codes,
// the packed result entry carried through the stage, and occupancy states.
package wb_pkg;

  localparam int WIDTH   = 16;
  localparam int RADDR_W = 3;

  typedef enum logic [1:0] {
    SEL_ALU = 2'b00,
    SEL_MEM = 2'b01,
    SEL_PC2 = 2'b10,
    SEL_IMM = 2'b11
  } sel_e;

  typedef struct packed {
    logic [WIDTH-1:0]   a0;
    logic [WIDTH-1:0]   a1;
    logic [WIDTH-1:0]   a2;
    logic [WIDTH-1:0]   a3;
    logic [1:0]         sel;
    logic [RADDR_W-1:0] rd;
    logic               we;
  } wb_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/wb_entry_reg.sv
// Entry-wide register with load enable and synchronous clear; clear wins over load.
module wb_entry_reg
  import wb_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr,
  input  logic      load,
  input  wb_entry_t d,
  output wb_entry_t q
);

  // NOTE: sequential state is written with <= so every register samples its
  // inputs from before the edge, independent of process ordering.
  // NOTE: the data fields are reset too, because the mux and register file see
  // them directly and must read zero out of reset and after a flush.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/wb_skid_stage.sv
// Writeback pipeline stage: MAIN drives the mux/register file, SKID absorbs one
// extra entry on a stall so in_ready can be a pure function of registered state.
module wb_skid_stage
  import wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a0,
  input  logic [WIDTH-1:0]   in_a1,
  input  logic [WIDTH-1:0]   in_a2,
  input  logic [WIDTH-1:0]   in_a3,
  input  logic [1:0]         in_sel,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_we,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   A0,
  output logic [WIDTH-1:0]   A1,
  output logic [WIDTH-1:0]   A2,
  output logic [WIDTH-1:0]   A3,
  output logic [1:0]         S,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_we
);

  occ_e      state_q, state_d;
  wb_entry_t in_entry, main_d, main_q, skid_q;
  logic      accept, pop;
  logic      main_load, main_clr, skid_load, skid_clr;

  assign in_entry = '{a0: in_a0, a1: in_a1, a2: in_a2, a3: in_a3,
                      sel: in_sel, rd: in_rd, we: in_we};

  // in_ready depends only on the state register, never on out_ready.
  assign in_ready  = (state_q != OCC_FULL);
  assign out_valid = (state_q != OCC_EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      unique case (state_q)
        OCC_EMPTY: if (accept) state_d = OCC_ONE;
        OCC_ONE: begin
          if (accept && !pop)      state_d = OCC_FULL;
          else if (!accept && pop) state_d = OCC_EMPTY;
        end
        OCC_FULL:  if (pop) state_d = OCC_ONE;
        default:   state_d = OCC_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_load = 1'b0;
    main_clr  = flush;
    skid_load = 1'b0;
    skid_clr  = flush;
    main_d    = in_entry;
    if (!flush) begin
      unique case (state_q)
        OCC_EMPTY: main_load = accept;
        OCC_ONE: begin
          main_load = pop && accept;
          main_clr  = pop && !accept;
          skid_load = accept && !pop;
        end
        OCC_FULL: begin
          // On a pop the held SKID entry moves up and SKID is emptied.
          main_d    = skid_q;
          main_load = pop;
          skid_clr  = pop;
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  wb_entry_reg u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (main_clr),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  wb_entry_reg u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (skid_clr),
    .load  (skid_load),
    .d     (in_entry),
    .q     (skid_q)
  );

  assign A0     = main_q.a0;
  assign A1     = main_q.a1;
  assign A2     = main_q.a2;
  assign A3     = main_q.a3;
  assign S      = main_q.sel;
  assign out_rd = main_q.rd;
  assign out_we = out_valid && main_q.we;

endmodule

// File: tb/tb_wb_skid_stage.sv
// Self-checking bench for wb_skid_stage: directed scenarios plus a randomised
// run checked against a depth-2 FIFO reference model.
module tb_wb_skid_stage;
  import wb_pkg::*;

  logic               clk, rst_n, flush, in_valid, in_ready;
  logic [WIDTH-1:0]   in_a0, in_a1, in_a2, in_a3;
  logic [1:0]         in_sel;
  logic [RADDR_W-1:0] in_rd;
  logic               in_we, out_valid, out_ready;
  logic [WIDTH-1:0]   A0, A1, A2, A3;
  logic [1:0]         S;
  logic [RADDR_W-1:0] out_rd;
  logic               out_we;

  int total = 0;
  int bad   = 0;

  wb_entry_t ref_q[$];   // entries the stage should currently hold, oldest first
  wb_entry_t dut_log[$]; // entries observed leaving the DUT

  wb_skid_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_a2(in_a2), .in_a3(in_a3),
    .in_sel(in_sel), .in_rd(in_rd), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3), .S(S),
    .out_rd(out_rd), .out_we(out_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic wb_entry_t cur_in();
    return '{a0: in_a0, a1: in_a1, a2: in_a2, a3: in_a3, sel: in_sel, rd: in_rd, we: in_we};
  endfunction

  function automatic wb_entry_t cur_out();
    return '{a0: A0, a1: A1, a2: A2, a3: A3, sel: S, rd: out_rd, we: out_we};
  endfunction

  task automatic drive(input logic v, input logic [WIDTH-1:0] a0, input logic [1:0] sel,
                       input logic [RADDR_W-1:0] rd, input logic we);
    in_valid = v;
    in_a0 = a0; in_a1 = a0 ^ 16'h5555; in_a2 = a0 + 16'd2; in_a3 = ~a0;
    in_sel = sel; in_rd = rd; in_we = we;
  endtask

  // Advance one clock, update the FIFO model, and log what the DUT handed out.
  task automatic step();
    logic acc, pop;
    acc = in_valid && (ref_q.size() < 2);
    pop = (ref_q.size() > 0) && out_ready;
    if (out_valid && out_ready) dut_log.push_back(cur_out());
    @(posedge clk);
    if (!rst_n || flush) begin
      ref_q.delete();
    end else begin
      if (pop) void'(ref_q.pop_front());
      if (acc) ref_q.push_back(cur_in());
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 16'hFFFF, SEL_IMM, 3'd7, 1'b1);
    step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if ({A0, A1, A2, A3} !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", {A0, A1, A2, A3}); end
    total++; if (S !== 2'b00 || out_rd !== '0) begin bad++; $display("FAIL reset_sel_rd got=%b/%0d want=0/0", S, out_rd); end
    total++; if (out_we !== 1'b0) begin bad++; $display("FAIL reset_out_we got=%b want=0", out_we); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    rst_n = 1'b1;
    drive(1'b0, '0, SEL_ALU, '0, 1'b0);
    step();
  endtask

  task automatic test_pass_through();
    out_ready = 1'b1;
    drive(1'b1, 16'h1234, SEL_ALU, 3'd3, 1'b1);
    step();
    drive(1'b0, '0, SEL_ALU, '0, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pass_valid got=%b want=1", out_valid); end
    total++; if (A0 !== 16'h1234) begin bad++; $display("FAIL pass_a0 got=%h want=1234", A0); end
    total++; if (S !== SEL_ALU || out_rd !== 3'd3) begin bad++; $display("FAIL pass_sel_rd got=%b/%0d want=00/3", S, out_rd); end
    total++; if (out_we !== 1'b1) begin bad++; $display("FAIL pass_we got=%b want=1", out_we); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pass_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_stall_fill();
    logic [WIDTH-1:0] vals [3] = '{16'hA001, 16'hA002, 16'hA003};
    int idx = 0;
    dut_log.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], SEL_MEM, 3'(i + 1), 1'b1);
      if (in_ready) idx++;
      step();
    end
    total++; if (idx !== 2) begin bad++; $display("FAIL stall_accepts got=%0d want=2", idx); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
    total++; if (A0 !== 16'hA001 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold got=%h/%b want=a001/1", A0, out_valid); end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (in_valid && in_ready) begin
        step();
        drive(1'b0, '0, SEL_ALU, '0, 1'b0);
      end else begin
        step();
      end
    end
    total++; if (dut_log.size() !== 3) begin bad++; $display("FAIL stall_count got=%0d want=3", dut_log.size()); end
    for (int i = 0; i < 3 && i < dut_log.size(); i++) begin
      total++;
      if (dut_log[i].a0 !== vals[i] || dut_log[i].rd !== 3'(i + 1)) begin
        bad++; $display("FAIL stall_order[%0d] got=%h want=%h", i, dut_log[i].a0, vals[i]);
      end
    end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    drive(1'b1, 16'hA001, SEL_PC2, 3'd1, 1'b1); step();
    drive(1'b1, 16'hA002, SEL_PC2, 3'd2, 1'b1); step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_prefull got=%b want=0", in_ready); end
    flush = 1'b1;
    drive(1'b1, 16'hBEEF, SEL_IMM, 3'd5, 1'b1);
    step();
    flush = 1'b0;
    drive(1'b0, '0, SEL_ALU, '0, 1'b0);
    total++; if (out_valid !== 1'b0 || out_we !== 1'b0) begin bad++; $display("FAIL flush_out got=%b/%b want=0/0", out_valid, out_we); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b want=1", in_ready); end
    total++; if (A0 !== '0) begin bad++; $display("FAIL flush_a0 got=%h want=0", A0); end
    dut_log.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    total++; if (dut_log.size() !== 0) begin bad++; $display("FAIL flush_leak got=%0d entries want=0", dut_log.size()); end
  endtask

  task automatic test_streaming();
    dut_log.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 16'h0100 + 16'(i), SEL_ALU, 3'(i), 1'(i));
      if (in_ready !== 1'b1) begin total++; bad++; $display("FAIL stream_ready cyc=%0d got=%b want=1", i, in_ready); end
      step();
    end
    drive(1'b0, '0, SEL_ALU, '0, 1'b0);
    step(); step();
    total++; if (dut_log.size() !== 100) begin bad++; $display("FAIL stream_count got=%0d want=100", dut_log.size()); end
    for (int i = 0; i < 100 && i < dut_log.size(); i++) begin
      total++;
      if (dut_log[i].a0 !== 16'h0100 + 16'(i) || dut_log[i].we !== 1'(i)) begin
        bad++; $display("FAIL stream_data[%0d] got=%h/%b want=%h/%b", i, dut_log[i].a0, dut_log[i].we, 16'h0100 + 16'(i), 1'(i));
      end
    end
  endtask

  task automatic test_random();
    wb_entry_t exp, snap;
    logic stall;
    int errs = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_a0 = 16'($urandom); in_a1 = 16'($urandom); in_a2 = 16'($urandom); in_a3 = 16'($urandom);
      in_sel = 2'($urandom); in_rd = 3'($urandom); in_we = 1'($urandom);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(63) == 0);
      total++;
      if (out_valid !== (ref_q.size() > 0) || in_ready !== (ref_q.size() < 2)) begin
        bad++; errs++;
        $display("FAIL rand_flags cyc=%0d got=%b/%b want=%b/%b", c, out_valid, in_ready, ref_q.size() > 0, ref_q.size() < 2);
      end
      if (ref_q.size() > 0) begin
        exp = ref_q[0];
        total++;
        if (cur_out() !== exp) begin
          bad++; errs++;
          $display("FAIL rand_entry cyc=%0d got=%h want=%h", c, cur_out(), exp);
        end
      end
      stall = out_valid && !out_ready && !flush;
      snap  = cur_out();
      step();
      if (stall) begin
        total++;
        if (cur_out() !== snap) begin
          bad++; errs++;
          $display("FAIL rand_stable cyc=%0d got=%h want=%h", c, cur_out(), snap);
        end
      end
      if (errs > 20) break;
    end
    flush = 1'b0;
    drive(1'b0, '0, SEL_ALU, '0, 1'b0);
  endtask

  initial begin
    drive(1'b0, '0, SEL_ALU, '0, 1'b0);
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_pass_through();
    test_stall_fill();
    test_flush_full();
    test_streaming();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout sim_time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end

endmodule
